// File: rtl/ide_port_a_seq.sv
// ide_port_a_seq: Port A (IDE side) sequencer for the sector DMA buffer.
//   Gates IDE DMA bursts against buffer space/data, counts 256-word blocks and
//   drives the buffer Port A strobes plus CRC arm/enable for SecCnt_i blocks.
//   Inputs : CLK4_i, nRST_i (async, low), DMA_ARM_i, PS2WrIDE_i (1 = buffer->drive),
//            SecCnt_i, DMARQ_i, IdeWordIn_i, IdeWordOut_i, PA_HvSpace_i, PA_OD_Rdy_i, A0_i
//   Outputs: EnbA_o, WrA_o, IncAddrA_o, RegEA_o, HWOE_o, CRC_ARM_o, CRC_ENB_o, DMACK_o,
//            DOutValid_o, BlkLeft_o, Busy_o, XferDone_o, Overrun_o
module ide_port_a_seq #(
   parameter int SEC_W = 8
) (
   input  logic             CLK4_i,
   input  logic             nRST_i,
   input  logic             DMA_ARM_i,
   input  logic             PS2WrIDE_i,
   input  logic [SEC_W-1:0] SecCnt_i,
   input  logic             DMARQ_i,
   input  logic             IdeWordIn_i,
   input  logic             IdeWordOut_i,
   input  logic             PA_HvSpace_i,
   input  logic             PA_OD_Rdy_i,
   input  logic             A0_i,
   output logic             EnbA_o,
   output logic             WrA_o,
   output logic             IncAddrA_o,
   output logic             RegEA_o,
   output logic             HWOE_o,
   output logic             CRC_ARM_o,
   output logic             CRC_ENB_o,
   output logic             DMACK_o,
   output logic             DOutValid_o,
   output logic [SEC_W:0]   BlkLeft_o,
   output logic             Busy_o,
   output logic             XferDone_o,
   output logic             Overrun_o
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_WFETCH, S_WREG, S_WHOLD, S_DONE} state_t;
   localparam logic [SEC_W:0] BLK_ONE = 1;
   state_t           state_q, state_d;
   logic             wr_q, wr_d;
   logic [SEC_W:0]   blk_q, blk_d;
   logic [7:0]       wcnt_q, wcnt_d;
   logic             ovr_q, ovr_d;
   logic             hwoe_q, hwoe_d;
   logic             dmack_q;
   logic             rd_ok, fetch, last;
   // DMACK is DMARQ delayed one cycle, shown only while a burst may run
   assign DMACK_o     = dmack_q && (state_q == S_RD || state_q == S_WHOLD);
   // a read word is only taken while acknowledged; buffer clear (arm low) suppresses it
   assign rd_ok       = DMA_ARM_i && state_q == S_RD && IdeWordIn_i && DMACK_o;
   assign fetch       = DMA_ARM_i && state_q == S_WFETCH;
   assign last        = wcnt_q == 8'hFF;
   assign EnbA_o      = rd_ok || fetch;
   assign IncAddrA_o  = rd_ok || fetch;
   assign WrA_o       = rd_ok;
   assign CRC_ENB_o   = rd_ok;
   assign RegEA_o     = DMA_ARM_i && state_q == S_WREG;
   assign HWOE_o      = hwoe_q && (state_q == S_WREG || state_q == S_WHOLD);
   assign DOutValid_o = state_q == S_WHOLD;
   assign CRC_ARM_o   = state_q != S_IDLE;
   assign Busy_o      = state_q != S_IDLE && state_q != S_DONE;
   assign XferDone_o  = state_q == S_DONE;
   assign Overrun_o   = ovr_q;
   assign BlkLeft_o   = blk_q;
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      blk_d   = blk_q;
      wcnt_d  = wcnt_q;
      ovr_d   = ovr_q;
      hwoe_d  = hwoe_q;
      if (!DMA_ARM_i) begin
         state_d = S_IDLE;
         wr_d    = 1'b0;
         blk_d   = '0;
         wcnt_d  = '0;
         ovr_d   = 1'b0;
         hwoe_d  = 1'b0;
      end else begin
         if (state_q != S_IDLE && ((IdeWordIn_i && !rd_ok) || (IdeWordOut_i && state_q != S_WHOLD)))
            ovr_d = 1'b1;
         case (state_q)
            // counters and flags are already zero in IDLE, so only load what the transfer needs
            S_IDLE: if (DMARQ_i) begin
               state_d = S_WAIT;
               wr_d    = PS2WrIDE_i;
               blk_d   = {SecCnt_i == '0, SecCnt_i};
            end
            S_WAIT: if (wr_q ? PA_OD_Rdy_i : PA_HvSpace_i) state_d = wr_q ? S_WFETCH : S_RD;
            S_RD, S_WHOLD: if (rd_ok || (state_q == S_WHOLD && IdeWordOut_i)) begin
               wcnt_d  = wcnt_q + 8'd1;
               blk_d   = last ? blk_q - BLK_ONE : blk_q;
               state_d = !last ? (state_q == S_RD ? S_RD : S_WFETCH) : (blk_q == BLK_ONE ? S_DONE : S_WAIT);
            end
            S_WFETCH: begin
               hwoe_d  = A0_i;
               state_d = S_WREG;
            end
            S_WREG: state_d = S_WHOLD;
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge CLK4_i or negedge nRST_i)
      if (!nRST_i) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         blk_q   <= '0;
         wcnt_q  <= '0;
         ovr_q   <= 1'b0;
         hwoe_q  <= 1'b0;
         dmack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         blk_q   <= blk_d;
         wcnt_q  <= wcnt_d;
         ovr_q   <= ovr_d;
         hwoe_q  <= hwoe_d;
         dmack_q <= DMARQ_i;
      end
endmodule

// File: tb/tb_ide_port_a_seq.sv
// tb_ide_port_a_seq: table, directed and random checks of ide_port_a_seq against a transfer-level model
module tb_ide_port_a_seq;
   localparam int SEC_W = 8;
   logic clk = 1'b0;
   logic nrst;
   logic arm = 0, wdir = 0, rq = 0, wi = 0, wo = 0, hv = 0, odr = 0, a0 = 0;
   logic [SEC_W-1:0] sec = '0;
   logic enba, wra, inca, rega, hwoe, crc_arm, crc_enb, dmack, dov, busy, xdone, ovr;
   logic [SEC_W:0] blk;
   logic [20:0] dut_out, snap;
   int n_vec = 0, n_bad = 0;
   int cnt_wra, cnt_fetch, cnt_rege, cnt_dmack, cnt_crc;
   // transfer-level model: words moved so far, whether the current block passed its buffer check
   bit m_act, m_dir, m_gate, m_rq_q, m_ovr, m_hwoe;
   int m_total, m_words, m_ph;
   typedef struct {
      bit arm, rq, wi, hv;
      logic [7:0] sec;
      logic [12:0] exp;
   } row_t;
   row_t tbl[16];

   always #5 clk = ~clk;

   ide_port_a_seq #(.SEC_W(SEC_W)) dut (
      .CLK4_i(clk), .nRST_i(nrst), .DMA_ARM_i(arm), .PS2WrIDE_i(wdir), .SecCnt_i(sec),
      .DMARQ_i(rq), .IdeWordIn_i(wi), .IdeWordOut_i(wo), .PA_HvSpace_i(hv), .PA_OD_Rdy_i(odr),
      .A0_i(a0), .EnbA_o(enba), .WrA_o(wra), .IncAddrA_o(inca), .RegEA_o(rega), .HWOE_o(hwoe),
      .CRC_ARM_o(crc_arm), .CRC_ENB_o(crc_enb), .DMACK_o(dmack), .DOutValid_o(dov),
      .BlkLeft_o(blk), .Busy_o(busy), .XferDone_o(xdone), .Overrun_o(ovr)
   );

   assign dut_out = {enba, wra, inca, rega, hwoe, crc_arm, crc_enb, dmack, dov, busy, xdone, ovr, blk};

   function automatic bit m_done();
      return m_act && m_words == m_total * 256;
   endfunction
   function automatic bit m_run();
      return m_act && !m_done() && m_gate;
   endfunction
   function automatic bit m_rd();
      return m_run() && !m_dir;
   endfunction
   function automatic bit m_wr();
      return m_run() && m_dir;
   endfunction
   function automatic bit m_hold();
      return m_wr() && m_ph == 2;
   endfunction
   function automatic bit m_ack();
      return m_rq_q && (m_rd() || m_hold());
   endfunction
   function automatic bit m_can_rd();
      return m_rd() && m_rq_q;
   endfunction

   function automatic logic [20:0] exp_out();
      bit rd_ok, fch;
      int blkv;
      rd_ok = arm && m_rd() && wi && m_ack();
      fch   = arm && m_wr() && m_ph == 0;
      blkv  = m_act ? m_total - m_words / 256 : 0;
      return {rd_ok || fch, rd_ok, rd_ok || fch, arm && m_wr() && m_ph == 1,
              (m_wr() && m_ph >= 1) ? m_hwoe : 1'b0, m_act, rd_ok, m_ack(), m_hold(),
              m_act && !m_done(), m_done(), m_ovr, 9'(blkv)};
   endfunction

   task automatic m_reset();
      m_act = 0; m_dir = 0; m_gate = 0; m_rq_q = 0; m_ovr = 0; m_hwoe = 0;
      m_total = 0; m_words = 0; m_ph = 0;
   endtask

   task automatic m_update();
      bit rd_ok, hold, waiting, wr;
      int ph;
      if (!nrst) begin
         m_reset();
         return;
      end
      rd_ok   = m_rd() && wi && m_ack();
      hold    = m_hold();
      waiting = m_act && !m_done() && !m_gate;
      wr      = m_wr();
      ph      = m_ph;
      if (!arm) m_reset();
      else if (!m_act) begin
         if (rq) begin
            m_act = 1; m_dir = wdir; m_total = (sec == 0) ? 256 : int'(sec);
            m_words = 0; m_gate = 0; m_ovr = 0; m_ph = 0;
         end
      end else begin
         if ((wi && !rd_ok) || (wo && !hold)) m_ovr = 1;
         if (waiting && (m_dir ? odr : hv)) begin
            m_gate = 1;
            m_ph = 0;
         end
         if (rd_ok) begin
            m_words++;
            if (m_words % 256 == 0) m_gate = 0;
         end
         if (wr) begin
            if (ph == 0) begin
               m_hwoe = a0;
               m_ph = 1;
            end else if (ph == 1) m_ph = 2;
            else if (wo) begin
               m_words++;
               m_ph = 0;
               if (m_words % 256 == 0) m_gate = 0;
            end
         end
      end
      m_rq_q = rq;
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // called at posedge+1 with inputs set; samples at the falling edge, then advances one clock
   task automatic step(string nm);
      #4;
      snap = dut_out;
      chk(nm, dut_out, exp_out());
      cnt_wra   += int'(wra);
      cnt_fetch += int'(enba && !wra && inca);
      cnt_rege  += int'(rega);
      cnt_dmack += int'(dmack);
      cnt_crc   += int'(crc_enb);
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic clr();
      cnt_wra = 0; cnt_fetch = 0; cnt_rege = 0; cnt_dmack = 0; cnt_crc = 0;
   endtask

   task automatic idle();
      arm = 0; rq = 0; wi = 0; wo = 0; hv = 0; odr = 0;
      step("idle");
      step("idle");
   endtask

   task automatic start(bit dir, int s);
      arm = 1; rq = 1; wdir = dir; sec = 8'(s); wi = 0; wo = 0; hv = 0; odr = 0;
      step("start");
      clr();
   endtask

   function automatic row_t mk(bit a, bit r, bit w, bit h, int s, bit ew, bit ed, bit eb, bit eo, int bl);
      row_t x;
      x.arm = a; x.rq = r; x.wi = w; x.hv = h; x.sec = 8'(s);
      x.exp = {ew, ed, eb, eo, 9'(bl)};
      return x;
   endfunction

   initial begin
      bit seen1, early;
      int k, hc;
      bit hold, dir;
      // expected {WrA, DMACK, Busy, Overrun, BlkLeft} for each applied cycle
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 1, 1, 0, 3, 0, 0, 1, 0, 3);
      tbl[3]  = mk(1, 1, 0, 1, 3, 0, 0, 1, 1, 3);
      tbl[4]  = mk(1, 1, 1, 1, 3, 1, 1, 1, 1, 3);
      tbl[5]  = mk(1, 0, 1, 1, 3, 1, 1, 1, 1, 3);
      tbl[6]  = mk(1, 0, 1, 1, 3, 0, 0, 1, 1, 3);
      tbl[7]  = mk(1, 1, 0, 1, 3, 0, 0, 1, 1, 3);
      tbl[8]  = mk(1, 1, 1, 1, 3, 1, 1, 1, 1, 3);
      tbl[9]  = mk(0, 1, 0, 1, 3, 0, 1, 1, 1, 3);
      tbl[10] = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
      tbl[11] = mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
      tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 256);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 256);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nrst = 1'b0;
      m_reset();
      clr();
      @(posedge clk);
      #1;
      chk("reset", dut_out, 0);
      nrst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         arm = tbl[i].arm; rq = tbl[i].rq; wi = tbl[i].wi; hv = tbl[i].hv; sec = tbl[i].sec;
         step("tbl_model");
         chk($sformatf("tbl%0d", i), {snap[19], snap[13], snap[11], snap[9], snap[8:0]}, 32'(tbl[i].exp));
      end

      // two-block read at full rate
      idle();
      start(0, 2);
      chk("rd2_load", blk, 2);
      hv = 1;
      seen1 = 0;
      for (int c = 0; c < 2000 && !m_done(); c++) begin
         wi = m_can_rd();
         step("rd2");
         if (blk == 1) seen1 = 1;
      end
      chk("rd2_wra", cnt_wra, 512);
      chk("rd2_blk1", seen1, 1);
      chk("rd2_done", xdone, 1);
      chk("rd2_dmack", dmack, 0);
      chk("rd2_ovr", ovr, 0);

      // read stalled on buffer space
      idle();
      start(0, 1);
      for (int c = 0; c < 20; c++) step("stall");
      chk("stall_wra", cnt_wra, 0);
      chk("stall_dmack", cnt_dmack, 0);
      hv = 1;
      for (int c = 0; c < 600 && !m_done(); c++) begin
         wi = m_can_rd();
         step("stall_rd");
      end
      chk("stall_wra_all", cnt_wra, 256);
      chk("stall_done", xdone, 1);

      // one-block write, word taken two cycles after DOutValid, A0 alternating
      idle();
      start(1, 1);
      odr = 1;
      k = 0;
      hc = 0;
      for (int c = 0; c < 2000 && !m_done(); c++) begin
         hold = m_hold();
         wo = hold && hc == 2;
         a0 = k[0];
         step("wr");
         if (wo) begin
            chk("hwoe_alt", 32'(snap[16]), 32'(k[0]));
            k++;
         end
         hc = (hold && !wo) ? hc + 1 : 0;
      end
      wo = 0;
      chk("wr_fetch", cnt_fetch, 256);
      chk("wr_rege", cnt_rege, 256);
      chk("wr_crc", cnt_crc, 0);
      chk("wr_done", xdone, 1);

      // IdeWordIn during WAIT_BUF
      idle();
      start(0, 1);
      wi = 1;
      step("wait_wi");
      wi = 0;
      chk("wait_ovr", ovr, 1);
      chk("wait_wra", cnt_wra, 0);

      // arm dropped at word 100, then re-armed
      idle();
      start(0, 2);
      hv = 1;
      for (int c = 0; c < 400 && cnt_wra < 100; c++) begin
         wi = m_can_rd();
         step("drop_rd");
      end
      chk("drop_w100", cnt_wra, 100);
      arm = 0;
      wi = 0;
      step("drop");
      chk("drop_zero", dut_out, 0);
      arm = 1;
      rq = 1;
      sec = 8'd2;
      step("rearm");
      chk("rearm_blk", blk, 2);
      chk("rearm_busy", busy, 1);

      // async reset while in WR_REG
      idle();
      start(1, 1);
      odr = 1;
      for (int c = 0; c < 20 && !(m_wr() && m_ph == 1); c++) step("g_seek");
      chk("g_wreg", rega, 1);
      #2;
      nrst = 1'b0;
      #1;
      chk("g_rst_zero", dut_out, 0);
      m_reset();
      @(posedge clk);
      #1;
      nrst = 1'b1;
      step("g_after");
      idle();

      // SecCnt = 0 means 256 blocks
      start(0, 0);
      chk("s0_load", blk, 256);
      hv = 1;
      early = 0;
      for (int c = 0; c < 70000 && !m_done(); c++) begin
         wi = m_can_rd();
         step("s0");
         if (xdone && cnt_wra < 65536) early = 1;
      end
      chk("s0_wra", cnt_wra, 65536);
      chk("s0_early", early, 0);
      chk("s0_done", xdone, 1);

      // randomized transfers
      for (int t = 0; t < 4; t++) begin
         idle();
         dir = 1'($urandom % 2);
         start(dir, 1 + int'($urandom % 2));
         for (int c = 0; c < 4000 && !m_done(); c++) begin
            rq  = ($urandom % 10) != 0;
            hv  = 1'($urandom % 2);
            odr = 1'($urandom % 2);
            a0  = 1'($urandom % 2);
            wi  = (!dir && m_can_rd() && ($urandom % 4) != 0) || ($urandom % 300) == 0;
            wo  = (dir && m_hold() && ($urandom % 2) != 0) || ($urandom % 300) == 0;
            step("rnd");
         end
         wi = 0;
         wo = 0;
         chk("rnd_done", xdone, 1);
      end
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ide_port_a_seq.md
# ide_port_a_seq

Sequencer for Port A (IDE side) of the sector DMA buffer. It gates IDE DMA bursts against buffer space and data, and counts 256-word blocks. It drives the buffer's Port A enable, write, address-increment, output-register and word-select controls, plus the CRC arm and enable, for a programmed number of 512-byte blocks in either direction. It sits between the IDE bus strobe logic and the buffer; the PS2 side (Port B) is sequenced independently.

## Interface
- SEC_W, 8: width of block-count load value; 0 encodes 2^SEC_W blocks
- CLK4  in  1  system clock, same clock as buffer and CRC
- nRST  in  1  asynchronous, active-low reset
- DMA_ARM  in  1  synchronous arm; low forces IDLE, same cycle semantics as buffer clear
- PS2WrIDE  in  1  1 = buffer→drive (write), 0 = drive→buffer (read); sampled on leaving IDLE
- SecCnt  in  SEC_W  blocks to transfer; sampled on leaving IDLE
- DMARQ  in  1  drive DMA request
- IdeWordIn  in  1  one-cycle pulse: drive word valid on buffer DInA (read direction)
- IdeWordOut  in  1  one-cycle pulse: IDE side consumed DOutA word (write direction)
- PA_HvSpace, PA_OD_Rdy  in  1 each  buffer status
- A0  in  1  buffer half-word select
- EnbA, WrA, IncAddrA, RegEA, HWOE  out  1 each  buffer Port A controls
- CRC_ARM, CRC_ENB  out  1 each  CRC clear/enable
- DMACK  out  1  DMA acknowledge to drive
- DOutValid  out  1  word on DOutA valid for IDE side
- BlkLeft  out  SEC_W+1  blocks remaining
- Busy, XferDone, Overrun  out  1 each  status; XferDone and Overrun sticky until next IDLE exit

## Operation
- States: IDLE, WAIT_BUF, RD_XFER, WR_FETCH, WR_REG, WR_HOLD, DONE.
- IDLE: all outputs 0.
  - When DMA_ARM=1 and DMARQ=1: load BlkLeft (SecCnt, 0→2^SEC_W), latch direction, clear the word counter (8 bit), XferDone and Overrun, and set CRC_ARM=1. Go to WAIT_BUF.
- WAIT_BUF:
  - Read direction: go to RD_XFER when PA_HvSpace=1.
  - Write direction: go to WR_FETCH when PA_OD_Rdy=1.
  - DMACK=0 in this state.
- RD_XFER:
  - DMACK=DMARQ (registered).
  - Each IdeWordIn: EnbA=WrA=IncAddrA=CRC_ENB=1 combinationally in that cycle; the word counter increments.
  - On the 256th word, BlkLeft decrements. Next state is DONE if BlkLeft becomes 0, else WAIT_BUF.
- WR_FETCH: EnbA=1, WrA=0, IncAddrA=1 for one cycle; HWOE register ← A0. Go to WR_REG.
- WR_REG: RegEA=1 for one cycle. Go to WR_HOLD.
- WR_HOLD:
  - DOutValid=1 and DMACK=DMARQ; HWOE is held.
  - On IdeWordOut, the word counter increments and DOutValid drops next cycle.
  - After the 256th word, BlkLeft decrements and next state is DONE or WAIT_BUF. Otherwise go to WR_FETCH.
- DONE: XferDone=1, DMACK=0, CRC_ARM stays 1 so CRC_Q is readable. Go to IDLE when DMA_ARM=0.
- Busy=1 in every state except IDLE and DONE.
- CRC_ENB is never asserted in write direction.
- Overrun is set on any of:
  - IdeWordIn outside RD_XFER;
  - IdeWordOut outside WR_HOLD;
  - IdeWordIn with DMACK=0.
- The offending pulse is ignored; no buffer control is issued.
- DMA_ARM=0 in any state: next cycle IDLE, all outputs 0 except the sticky flags, which also clear.
- nRST low: immediately IDLE; all outputs and counters 0.
- DMARQ low mid-block: DMACK follows low, state and counters are held, and the block resumes when DMARQ returns.

## Timing
- Read: IdeWordIn at cycle n → EnbA/WrA/IncAddrA/CRC_ENB at cycle n (zero latency). The next word is accepted at n+1.
- Write, per word:
  - FETCH at n, RegEA at n+1, DOutValid at n+2.
  - IdeWordOut at m ≥ n+2 → FETCH at m+1.
  - Minimum 3 cycles per word.
- Block boundary: the WAIT_BUF check happens the cycle after the 256th word, so back-to-back blocks cost at least 1 idle cycle.
- HWOE equals the A0 value captured at FETCH, held through WR_HOLD.
- The BlkLeft decrement and the XferDone rise occur in the same cycle as the DONE entry.

## Test plan
- Read, SecCnt=2, PA_HvSpace=1, IdeWordIn every cycle → exactly 512 WrA pulses; BlkLeft 2→1→0; XferDone=1; DMACK=0 after word 512.
- Read, SecCnt=1, PA_HvSpace=0 for 20 cycles then 1 → DMACK stays 0 and no WrA during the stall; transfer then completes with 256 WrA pulses.
- Write, SecCnt=1, PA_OD_Rdy=1, IdeWordOut 2 cycles after each DOutValid → 256 FETCH/RegEA pairs; HWOE alternates 0,1,0,1…
- SecCnt=0 → BlkLeft loads 256 (SEC_W=8) and XferDone only after 65536 words.
- IdeWordIn while in WAIT_BUF → Overrun=1; no WrA, word counter unchanged.
- DMA_ARM dropped at word 100 of a read, then re-armed → IDLE next cycle, outputs 0; a fresh transfer restarts with BlkLeft reloaded. Repeat with nRST asserted mid-WR_REG → immediate all-zero outputs.
